// File: rtl/i2s_tx.sv
// I2S transmitter: one-deep sample buffer, mono sample sent in both left and right slots.
// Latency: a sample buffered during frame N is sent in frame N+1; status pulses are registered, one clk after their event.
// Backpressure: none; frame_o requests the next sample, an overwritten sample raises ovf_o and an empty frame start raises udf_o.
module i2s_tx #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int SCLK_DIV   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  vld_i,
  output logic                  sclk,
  output logic                  lrck,
  output logic                  sd,
  output logic                  frame_o,
  output logic                  udf_o,
  output logic                  ovf_o
);

  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_WIDTH);

  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  full;

  logic                  div_tc;
  logic                  fall;
  logic                  wrap;
  logic [BIT_W-1:0]      bit_nxt;
  logic [BIT_W-1:0]      slot_pos;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic                  lrck_nxt;
  logic                  sd_nxt;

  // Edge detection and the bit position / data bit presented after the next SCLK falling edge.
  always_comb begin
    div_tc    = (div_cnt == DIV_W'(SCLK_DIV - 1));
    fall      = div_tc & sclk;
    wrap      = fall & (bit_cnt == BIT_W'(2 * SLOT_WIDTH - 1));
    bit_nxt   = wrap ? '0 : bit_cnt + BIT_W'(1);
    shift_nxt = (wrap && full) ? hold_q : shift_q;
    lrck_nxt  = (bit_nxt >= BIT_W'(SLOT_WIDTH));
    slot_pos  = lrck_nxt ? (bit_nxt - BIT_W'(SLOT_WIDTH)) : bit_nxt;
    sd_nxt    = 1'b0;
    // Slot position 0 is the I2S one-bit delay; positions past the sample are padding zeros.
    for (int i = 1; i <= DATA_WIDTH; i++) begin
      if (slot_pos == BIT_W'(i)) sd_nxt = shift_nxt[DATA_WIDTH-i];
    end
  end

  // Bit-clock divider: toggle sclk every SCLK_DIV clk cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (div_tc) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Bit position, word select and data change only on SCLK falling edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
      lrck    <= 1'b0;
      sd      <= 1'b0;
    end else if (fall) begin
      bit_cnt <= bit_nxt;
      lrck    <= lrck_nxt;
      sd      <= sd_nxt;
    end
  end

  // Sample buffer: a new strobe always wins; frame start moves the buffered sample into the shifter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q  <= '0;
      shift_q <= '0;
      full    <= 1'b0;
    end else begin
      shift_q <= shift_nxt;
      if (vld_i) begin
        hold_q <= data_i;
        full   <= 1'b1;
      end else if (wrap && full) begin
        full   <= 1'b0;
      end
    end
  end

  // Status pulses; a strobe coinciding with frame start is neither an overrun nor an underrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_o <= 1'b0;
      udf_o   <= 1'b0;
      ovf_o   <= 1'b0;
    end else begin
      frame_o <= wrap;
      udf_o   <= wrap & ~full & ~vld_i;
      ovf_o   <= vld_i & full & ~wrap;
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: cycle-count based reference model, per-cycle output compare, serial word decoder.
// Directed scenarios (reset, transfer, underrun, overrun, simultaneous strobe, mid-frame reset) then random strobes.
// Inputs change on the falling clk edge; outputs are compared on the falling clk edge.
module tb_i2s_tx;

  localparam int DW    = 24;
  localparam int SW    = 32;
  localparam int SD    = 2;
  localparam int FRAME = 2 * SD * 2 * SW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          vld_i = 1'b0;
  logic          sclk, lrck, sd, frame_o, udf_o, ovf_o;

  int checks = 0;
  int failures = 0;

  i2s_tx #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .SCLK_DIV(SD)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .vld_i(vld_i),
    .sclk(sclk), .lrck(lrck), .sd(sd),
    .frame_o(frame_o), .udf_o(udf_o), .ovf_o(ovf_o)
  );

  initial forever #5 clk = ~clk;

  // Reference model: k = clk edges since reset release; all bus timing is arithmetic on k.
  int            k;
  bit            fs;
  logic          m_full;
  logic [DW-1:0] m_hold, m_cur;
  logic          e_frame, e_udf, e_ovf;

  initial begin
    k = 0; m_full = 0; m_hold = '0; m_cur = '0; e_frame = 0; e_udf = 0; e_ovf = 0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        k = 0; m_full = 0; m_hold = '0; m_cur = '0; e_frame = 0; e_udf = 0; e_ovf = 0;
      end else begin
        k = k + 1;
        fs = (k % FRAME) == 0;
        e_frame = fs;
        e_udf = fs && !m_full && !vld_i;
        e_ovf = vld_i && m_full && !fs;
        if (fs && m_full) begin
          m_cur = m_hold;
          m_full = 0;
        end
        if (vld_i) begin
          m_hold = data_i;
          m_full = 1;
        end
      end
    end
  end

  function automatic logic exp_sclk(input int kk);
    return ((kk / SD) % 2) == 1;
  endfunction

  function automatic logic exp_lrck(input int kk);
    return ((kk / (2 * SD)) % (2 * SW)) >= SW;
  endfunction

  function automatic logic exp_sd(input int kk, input logic [DW-1:0] x);
    int p, s;
    logic [DW-1:0] t;
    p = (kk / (2 * SD)) % (2 * SW);
    s = p % SW;
    if (s == 0 || s > DW) return 1'b0;
    t = x >> (DW - s);
    return t[0];
  endfunction

  task automatic check(input string nm, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s: got %0h expected %0h (k=%0d, t=%0t)", nm, act, exp, k, $time);
    end
  endtask

  // Per-cycle compare of every output against the model.
  initial forever begin
    @(negedge clk);
    check("sclk",    48'(sclk),    48'(exp_sclk(k)));
    check("lrck",    48'(lrck),    48'(exp_lrck(k)));
    check("sd",      48'(sd),      48'(exp_sd(k, m_cur)));
    check("frame_o", 48'(frame_o), 48'(e_frame));
    check("udf_o",   48'(udf_o),   48'(e_udf));
    check("ovf_o",   48'(ovf_o),   48'(e_ovf));
  end

  // Serial decoder: sample sd on each sclk rise; a complete frame is pushed as {left, right} at frame_o.
  logic [63:0] sh;
  logic [47:0] rx_q[$];
  logic        prev_sclk;
  int          pos, n_udf, n_ovf;

  initial begin
    sh = '0; prev_sclk = 0; pos = 0; n_udf = 0; n_ovf = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pos = 0;
        prev_sclk = 0;
      end else begin
        if (udf_o) n_udf++;
        if (ovf_o) n_ovf++;
        if (frame_o) begin
          if (pos == 64) rx_q.push_back({sh[62:39], sh[30:7]});
          pos = 0;
        end
        if (!prev_sclk && sclk) begin
          sh = {sh[62:0], sd};
          pos++;
        end
        prev_sclk = sclk;
      end
    end
  end

  task automatic wait_k(input int target);
    int n;
    n = 0;
    while (k != target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (k != target) begin
      checks++;
      failures++;
      $display("FAIL wait_k: reached k=%0d, required k=%0d", k, target);
    end
  endtask

  task automatic send(input int kt, input logic [DW-1:0] d);
    wait_k(kt);
    vld_i = 1'b1;
    data_i = d;
    @(negedge clk);
    vld_i = 1'b0;
  endtask

  task automatic check_rx(input string nm, input logic [DW-1:0] word);
    if (rx_q.size() == 0) check(nm, 48'hDEAD, {word, word});
    else check(nm, rx_q[$], {word, word});
  endtask

  int n0;

  initial begin
    repeat (5) @(negedge clk);
    check("reset_outputs", 48'({sclk, lrck, sd, frame_o, udf_o, ovf_o}), 48'd0);
    #2 rst = 1'b1;

    // Bit clock period of 4 clk, first rise 2 clk after release; left slot is 32 SCLK periods.
    wait_k(1);   check("sclk_k1", 48'(sclk), 48'd0);
    wait_k(2);   check("sclk_k2", 48'(sclk), 48'd1);
    wait_k(4);   check("sclk_k4", 48'(sclk), 48'd0);
    wait_k(6);   check("sclk_k6", 48'(sclk), 48'd1);
    wait_k(127); check("lrck_k127", 48'(lrck), 48'd0);
    wait_k(128); check("lrck_k128", 48'(lrck), 48'd1);

    // Normal transfer, then underrun with retransmission.
    send(150, 24'hA5C3F0);
    wait_k(257); check_rx("first_frame_zero", 24'h000000);
    send(300, 24'h123456);
    wait_k(513); check_rx("normal_A5C3F0", 24'hA5C3F0);
    check("udf_cnt_513", 48'(n_udf), 48'd0);
    check("ovf_cnt_513", 48'(n_ovf), 48'd0);

    // Overrun: two strobes in one frame, newest wins.
    send(800, 24'h111111);
    send(850, 24'h222222);
    wait_k(1025);
    check_rx("underrun_resend", 24'h123456);
    check("udf_cnt_1025", 48'(n_udf), 48'd1);
    check("ovf_cnt_1025", 48'(n_ovf), 48'd1);

    // Strobe exactly on the frame-start edge while the buffer is full.
    send(1100, 24'h444444);
    send(1279, 24'h333333);
    wait_k(1281); check_rx("overrun_222222", 24'h222222);
    wait_k(1537); check_rx("simul_444444", 24'h444444);
    check("udf_cnt_1537", 48'(n_udf), 48'd1);
    check("ovf_cnt_1537", 48'(n_ovf), 48'd1);
    wait_k(1793); check_rx("simul_333333", 24'h333333);

    // Mid-frame reset at bit 40 with a sample buffered; buffer must be discarded.
    send(1900, 24'h555555);
    wait_k(1954);
    #2 rst = 1'b0;
    #1 check("midreset_outputs", 48'({sclk, lrck, sd, frame_o, udf_o, ovf_o}), 48'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    n0 = n_udf;
    wait_k(257);
    check_rx("post_reset_frame0", 24'h000000);
    check("post_reset_udf", 48'(n_udf), 48'(n0 + 1));
    wait_k(513);
    check_rx("post_reset_frame1", 24'h000000);

    // Random strobes, some deliberately on frame-start edges.
    repeat (4000) begin
      @(negedge clk);
      vld_i = ($urandom_range(0, 149) == 0) ||
              (((k % FRAME) == FRAME - 1) && ($urandom_range(0, 1) == 1));
      data_i = DW'($urandom);
    end
    @(negedge clk);
    vld_i = 1'b0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
Audio output serializer at the far end of the effect chain. It takes one mono sample per `vld_i` strobe (the same `data`/`vld` format the effects blocks emit) and holds it in a one-deep buffer. It then serializes that sample onto a standard I2S bus (`sclk`, `lrck`, `sd`) that drives the DAC, sending the same sample in both the left and right slots. It also returns a per-frame sample-request strobe and underrun/overrun status pulses to the upstream logic.

Parameters:
- DATA_WIDTH, 24, sample width in bits.
- SLOT_WIDTH, 32, SCLK periods per channel slot. Must be ≥ DATA_WIDTH+1.
- SCLK_DIV, 2, `clk` cycles per SCLK half-period. Must be ≥ 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- data_i  in  DATA_WIDTH  sample, two's complement.
- vld_i  in  1  one-cycle strobe; `data_i` is valid when high.
- sclk  out  1  I2S bit clock.
- lrck  out  1  I2S word select: 0 = left slot, 1 = right slot.
- sd  out  1  I2S serial data.
- frame_o  out  1  one-cycle pulse at each frame start (sample request).
- udf_o  out  1  one-cycle pulse: frame started with the buffer empty.
- ovf_o  out  1  one-cycle pulse: a buffered sample was overwritten.

Behaviour:
- Reset (`rst`=0, asynchronous): every register clears.
  - `div_cnt`, `bit_cnt`, `hold_q`, `full`, `shift_q` = 0.
  - All outputs = 0.
  - Takes effect immediately, mid-frame included. The next frame starts clean.
- Clock divider:
  - `div_cnt` counts 0..SCLK_DIV-1.
  - At terminal count, `div_cnt` wraps and `sclk` toggles.
  - `sclk` period = 2·SCLK_DIV `clk` cycles. The first rising edge comes SCLK_DIV cycles after reset release.
- Falling-edge event: the `clk` cycle in which `sclk` goes 1→0.
  - All `lrck`/`sd` changes occur only here, so the DAC samples on the `sclk` rising edge.
  - `bit_cnt` (0..2·SLOT_WIDTH-1) increments on this event and wraps to 0.
- Frame start: the falling-edge event where `bit_cnt` wraps 2·SLOT_WIDTH-1 → 0. On that cycle:
  - `frame_o` pulses.
  - If `full`=1: `shift_q` ← `hold_q` and `full` ← 0.
  - If `full`=0: `shift_q` keeps the previous sample and `udf_o` pulses.
  - The very first frame after reset (`bit_cnt`=0, no wrap) transmits zeros and raises no `frame_o` or `udf_o`.
- Slot mapping, with s = `bit_cnt` mod SLOT_WIDTH:
  - `lrck` = (`bit_cnt` ≥ SLOT_WIDTH).
  - s=0: `sd` = 0. This is the one-bit I2S delay after each `lrck` change.
  - s=1..DATA_WIDTH: `sd` = `shift_q`[DATA_WIDTH-s], i.e. MSB first.
  - s>DATA_WIDTH: `sd` = 0.
  - The right slot resends the same `shift_q`.
- Input buffer:
  - On `vld_i`=1: `hold_q` ← `data_i` and `full` ← 1.
  - If `full` was already 1 and no frame start occurs in that cycle, `ovf_o` pulses; the newest sample wins.
  - If `vld_i` and frame start occur in the same cycle: `shift_q` takes the old `hold_q`, `hold_q` takes `data_i`, `full` stays 1, and no `ovf_o` pulses.
  - If `vld_i` arrives at frame start with `full`=0: no underrun is flagged. The new sample loads `hold_q` directly and is transmitted the following frame.
- Status outputs: all registered, one cycle wide, never asserted in the same cycle as reset.

Test Plan (SCLK_DIV=2, SLOT_WIDTH=32, DATA_WIDTH=24; frame = 256 `clk`):
- Reset check: hold `rst`=0 → all outputs 0. After release, `sclk` period is 4 clk; the first frame has `lrck` low for 32 SCLK and high for 32, `sd`=0 throughout.
- Normal transfer: `vld_i` with 0xA5C3F0 during frame 0 → `frame_o` at the wrap. Left slot carries `sd`=0 at s=0, then bits 1010_0101_1100_0011_1111_0000 at s=1..24, then 0 at s=25..31. The right slot is identical. `udf_o` and `ovf_o` stay 0.
- Underrun: load 0x123456, then send no `vld_i` for one frame → `udf_o` pulses exactly once at that frame start and 0x123456 is retransmitted in both slots.
- Overrun: two `vld_i` (0x111111, then 0x222222) inside one frame → one `ovf_o` pulse on the second strobe; the next frame transmits 0x222222.
- Simultaneous: `vld_i`=0x333333 in the frame-start cycle while `hold_q`=0x444444 is full → the next frame sends 0x444444 and the frame after sends 0x333333, with no `ovf_o` or `udf_o`.
- Mid-frame reset: drive `rst`=0 at `bit_cnt`=40 for 3 cycles → `sclk`/`lrck`/`sd`/`frame_o` drop to 0 asynchronously and the buffer empties. After release, timing restarts as in the reset check, and the first post-reset wrap pulses `udf_o`.
